dft_frame_sched: RTL and testbench

- Frame-level scheduler between the SPI slave receiver, the mSDF DFT/bandpower datapath and the SPI transmit buffer.
- Collects a programmable number of samples per frame and forwards each to the DFT with a sample index.
- Fires one compute start per frame, then waits for bandpower done, latches the BAND_NUM results and streams them word-by-word to SPI TX.
- Samples arriving while the datapath is busy are dropped and flagged.

---
 rtl/dft_frame_sched.sv | 181 ++++++++++++++++++
 tb/tb_dft_frame_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dft_frame_sched.sv
// Frame scheduler: SPI RX samples -> DFT sample strobes, one compute start per frame, bandpower results -> SPI TX words.
// Define DFT_SCHED_HEADER_EN to prefix each frame's TX burst with a {8'hA5, frame_cnt[7:0]} header word (needs spi_s_width >= 16).
module dft_frame_sched #(
    parameter int WIDTH       = 16,
    parameter int N_MAX       = 512,
    parameter int LOG_N_MAX   = $clog2(N_MAX),
    parameter int BAND_NUM    = 2,
    parameter int spi_s_width = 16
) (
    input  logic                      i_sys_clk,
    input  logic                      i_sys_rst,
    input  logic                      i_enable,
    input  logic [LOG_N_MAX:0]        i_frame_len,
    input  logic                      i_rx_valid,
    input  logic [WIDTH-1:0]          i_rx_data,
    output logic                      o_x_valid,
    output logic [WIDTH-1:0]          o_x,
    output logic [LOG_N_MAX-1:0]      o_x_idx,
    output logic                      o_frame_start,
    input  logic                      i_bp_done,
    input  logic [BAND_NUM*WIDTH-1:0] i_bp_y,
    output logic [spi_s_width-1:0]    o_tx_data,
    output logic                      o_tx_load,
    input  logic                      i_tx_ready,
    output logic                      o_busy,
    output logic                      o_overrun,
    output logic [15:0]               o_frame_cnt
);

`ifdef DFT_SCHED_HEADER_EN
    localparam int N_WORDS = BAND_NUM + 1;
`else
    localparam int N_WORDS = BAND_NUM;
`endif
    localparam int                   PTR_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(N_WORDS - 1);
    localparam logic [LOG_N_MAX:0]   LEN_MAX  = (LOG_N_MAX + 1)'(N_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_COMPUTE,
        S_SEND,
        S_WAIT_TX
    } state_t;

    state_t                    state_q;
    logic [LOG_N_MAX-1:0]      n_q;
    logic [LOG_N_MAX-1:0]      last_idx_q;
    logic [BAND_NUM*WIDTH-1:0] y_q;
    logic [PTR_W-1:0]          ptr_q;
    logic                      start_pend_q;

    logic                      x_valid_q;
    logic [WIDTH-1:0]          x_q;
    logic [LOG_N_MAX-1:0]      x_idx_q;
    logic                      frame_start_q;
    logic [spi_s_width-1:0]    tx_data_q;
    logic                      tx_load_q;
    logic                      overrun_q;
    logic [15:0]               frame_cnt_q;

    logic [LOG_N_MAX:0]        len_eff;
    logic [LOG_N_MAX-1:0]      last_idx_d;
    logic [spi_s_width-1:0]    tx_word;
    logic                      busy;

    // Zero or over-range lengths fall back to a full-size frame.
    assign len_eff    = (i_frame_len == '0 || i_frame_len > LEN_MAX) ? LEN_MAX : i_frame_len;
    assign last_idx_d = LOG_N_MAX'(len_eff - 1'b1);
    assign busy       = (state_q != S_IDLE) && (state_q != S_COLLECT);

    always_comb begin
        tx_word = '0;
`ifdef DFT_SCHED_HEADER_EN
        if (ptr_q == '0) begin
            tx_word[15:0] = {8'hA5, frame_cnt_q[7:0]};
        end else begin
            tx_word[WIDTH-1:0] = y_q[(int'(ptr_q) - 1) * WIDTH +: WIDTH];
        end
`else
        tx_word[WIDTH-1:0] = y_q[int'(ptr_q) * WIDTH +: WIDTH];
`endif
    end

    // NOTE: every state and output register here uses <= so all of them see the pre-edge values of each other.
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst) begin
            state_q       <= S_IDLE;
            n_q           <= '0;
            last_idx_q    <= '0;
            // NOTE: the result latch is cleared as well, so a reset can never leak a stale band onto o_tx_data.
            y_q           <= '0;
            ptr_q         <= '0;
            start_pend_q  <= 1'b0;
            x_valid_q     <= 1'b0;
            x_q           <= '0;
            x_idx_q       <= '0;
            frame_start_q <= 1'b0;
            tx_data_q     <= '0;
            tx_load_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            x_valid_q     <= 1'b0;
            tx_load_q     <= 1'b0;
            start_pend_q  <= 1'b0;
            frame_start_q <= start_pend_q;

            if (i_rx_valid && busy) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (i_enable) begin
                        state_q    <= S_COLLECT;
                        n_q        <= '0;
                        last_idx_q <= last_idx_d;
                    end
                end
                S_COLLECT: begin
                    if (i_rx_valid) begin
                        x_valid_q <= 1'b1;
                        x_q       <= i_rx_data;
                        x_idx_q   <= n_q;
                        if (n_q == last_idx_q) begin
                            start_pend_q <= 1'b1;
                            n_q          <= '0;
                            state_q      <= S_COMPUTE;
                        end else begin
                            n_q <= n_q + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (i_bp_done) begin
                        y_q     <= i_bp_y;
                        ptr_q   <= '0;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (i_tx_ready) begin
                        tx_data_q <= tx_word;
                        tx_load_q <= 1'b1;
                        state_q   <= S_WAIT_TX;
                    end
                end
                S_WAIT_TX: begin
                    // One idle cycle between loads lets the TX buffer drop its ready flag.
                    if (ptr_q != LAST_PTR) begin
                        ptr_q   <= ptr_q + 1'b1;
                        state_q <= S_SEND;
                    end else begin
                        frame_cnt_q <= frame_cnt_q + 1'b1;
                        if (i_enable) begin
                            state_q    <= S_COLLECT;
                            n_q        <= '0;
                            last_idx_q <= last_idx_d;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_x_valid     = x_valid_q;
    assign o_x           = x_q;
    assign o_x_idx       = x_idx_q;
    assign o_frame_start = frame_start_q;
    assign o_tx_data     = tx_data_q;
    assign o_tx_load     = tx_load_q;
    assign o_busy        = busy;
    assign o_overrun     = overrun_q;
    assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_dft_frame_sched.sv
// Directed + randomized bench for dft_frame_sched; expectations come from a frame-level model (sample list, word list).
module tb_dft_frame_sched;
    localparam int WIDTH     = 16;
    localparam int N_MAX     = 512;
    localparam int LOG_N_MAX = $clog2(N_MAX);
    localparam int BAND_NUM  = 2;
    localparam int SPI_W     = 16;

    logic                      clk = 1'b0;
    logic                      i_sys_rst = 1'b0;
    logic                      i_enable = 1'b0;
    logic [LOG_N_MAX:0]        i_frame_len = '0;
    logic                      i_rx_valid = 1'b0;
    logic [WIDTH-1:0]          i_rx_data = '0;
    logic                      o_x_valid;
    logic [WIDTH-1:0]          o_x;
    logic [LOG_N_MAX-1:0]      o_x_idx;
    logic                      o_frame_start;
    logic                      i_bp_done = 1'b0;
    logic [BAND_NUM*WIDTH-1:0] i_bp_y = '0;
    logic [SPI_W-1:0]          o_tx_data;
    logic                      o_tx_load;
    logic                      i_tx_ready = 1'b0;
    logic                      o_busy;
    logic                      o_overrun;
    logic [15:0]               o_frame_cnt;

    dft_frame_sched #(
        .WIDTH(WIDTH), .N_MAX(N_MAX), .LOG_N_MAX(LOG_N_MAX),
        .BAND_NUM(BAND_NUM), .spi_s_width(SPI_W)
    ) dut (
        .i_sys_clk(clk), .i_sys_rst(i_sys_rst), .i_enable(i_enable),
        .i_frame_len(i_frame_len), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
        .o_x_valid(o_x_valid), .o_x(o_x), .o_x_idx(o_x_idx),
        .o_frame_start(o_frame_start), .i_bp_done(i_bp_done), .i_bp_y(i_bp_y),
        .o_tx_data(o_tx_data), .o_tx_load(o_tx_load), .i_tx_ready(i_tx_ready),
        .o_busy(o_busy), .o_overrun(o_overrun), .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    // Event recorder on the falling edge, away from where the DUT updates.
    int          cyc = 0;
    logic [15:0] xq_data[$];
    int          xq_idx[$];
    int          xq_cyc[$];
    int          start_n = 0;
    int          start_cyc = 0;
    logic [15:0] txq[$];
    int          txq_cyc[$];
    int          ready_viol = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (o_x_valid) begin
            xq_data.push_back(o_x);
            xq_idx.push_back(int'(o_x_idx));
            xq_cyc.push_back(cyc);
        end
        if (o_frame_start) begin
            start_n   = start_n + 1;
            start_cyc = cyc;
        end
        if (o_tx_load) begin
            txq.push_back(o_tx_data);
            txq_cyc.push_back(cyc);
            if (!i_tx_ready) ready_viol = ready_viol + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic [15:0] d, input int max_gap);
        i_rx_valid = 1'b1;
        i_rx_data  = d;
        tick();
        i_rx_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) tick();
    endtask

    function automatic int eff_len(input int len);
        return (len == 0 || len > N_MAX) ? N_MAX : len;
    endfunction

    // Reference model of the per-frame TX word list.
    logic [15:0] exp_words[$];
    task automatic build_words(input logic [15:0] cnt, input logic [BAND_NUM*WIDTH-1:0] y);
        exp_words.delete();
`ifdef DFT_SCHED_HEADER_EN
        exp_words.push_back({8'hA5, cnt[7:0]});
`endif
        for (int b = 0; b < BAND_NUM; b++) exp_words.push_back(y[b*WIDTH +: WIDTH]);
    endtask

    task automatic check_x(input string tag, input int xbase, input int sbase, input logic [15:0] smp[$]);
        int bad;
        int got;
        bad = 0;
        got = xq_data.size() - xbase;
        chk({tag, "_count"}, 64'(got), 64'(smp.size()));
        for (int i = 0; i < smp.size() && i < got; i++) begin
            if (xq_data[xbase+i] !== smp[i] || xq_idx[xbase+i] != i) bad++;
        end
        chk({tag, "_data_idx_mismatches"}, 64'(bad), 64'd0);
        chk({tag, "_frame_start_count"}, 64'(start_n - sbase), 64'd1);
        if (got > 0) chk({tag, "_frame_start_cycle"}, 64'(start_cyc), 64'(xq_cyc[xq_cyc.size()-1] + 1));
    endtask

    task automatic check_tx(input string tag, input int tbase);
        int got;
        got = txq.size() - tbase;
        chk({tag, "_word_count"}, 64'(got), 64'(exp_words.size()));
        for (int i = 0; i < exp_words.size() && i < got; i++) begin
            chk($sformatf("%s_word%0d", tag, i), 64'(txq[tbase+i]), 64'(exp_words[i]));
            if (i > 0) chk($sformatf("%s_gap%0d", tag, i), 64'(txq_cyc[tbase+i] - txq_cyc[tbase+i-1] >= 2), 64'd1);
        end
    endtask

    task automatic wait_cnt(input string tag, input logic [15:0] target, input int budget);
        for (int k = 0; k < budget && o_frame_cnt !== target; k++) tick();
        chk(tag, 64'(o_frame_cnt), 64'(target));
    endtask

    task automatic check_zero(input string p);
        chk({p, "_x_valid"},     64'(o_x_valid),     64'd0);
        chk({p, "_x"},           64'(o_x),           64'd0);
        chk({p, "_x_idx"},       64'(o_x_idx),       64'd0);
        chk({p, "_frame_start"}, 64'(o_frame_start), 64'd0);
        chk({p, "_tx_data"},     64'(o_tx_data),     64'd0);
        chk({p, "_tx_load"},     64'(o_tx_load),     64'd0);
        chk({p, "_busy"},        64'(o_busy),        64'd0);
        chk({p, "_overrun"},     64'(o_overrun),     64'd0);
        chk({p, "_frame_cnt"},   64'(o_frame_cnt),   64'd0);
    endtask

    initial begin
        logic [15:0]               smp[$];
        logic [BAND_NUM*WIDTH-1:0] y;
        int                        xbase, sbase, tbase, len, raise_cyc;

        // Reset state
        repeat (3) tick();
        check_zero("reset");
        i_sys_rst  = 1'b1;
        i_tx_ready = 1'b1;
        tick();

        // Frame A: len 4, samples 2,1,2,1; length change and enable drop mid-frame are ignored
        i_enable    = 1'b1;
        i_frame_len = 4;
        tick();
        xbase = xq_data.size(); sbase = start_n; tbase = txq.size();
        smp = '{16'd2, 16'd1, 16'd2, 16'd1};
        send_sample(16'd2, 1);
        send_sample(16'd1, 1);
        i_frame_len = 7;
        i_enable    = 1'b0;
        send_sample(16'd2, 1);
        send_sample(16'd1, 0);
        repeat (2) tick();
        check_x("frameA", xbase, sbase, smp);
        chk("frameA_busy_in_compute", 64'(o_busy), 64'd1);
        y = {16'h0034, 16'h0012};
        build_words(16'd0, y);
        i_bp_y = y; i_bp_done = 1'b1; tick(); i_bp_done = 1'b0;
        wait_cnt("frameA_frame_cnt", 16'd1, 40);
        check_tx("frameA", tbase);
        tick();
        chk("frameA_idle_busy", 64'(o_busy), 64'd0);

        // Samples and bp_done in IDLE are ignored silently
        xbase = xq_data.size();
        send_sample(16'h7777, 0);
        i_bp_done = 1'b1; tick(); i_bp_done = 1'b0;
        repeat (2) tick();
        chk("idle_rx_no_x_valid", 64'(xq_data.size() - xbase), 64'd0);
        chk("idle_rx_no_overrun", 64'(o_overrun), 64'd0);

        // Frame B: len 0 -> full 512 samples, overrun during COMPUTE, TX stall
        i_frame_len = 0;
        i_enable    = 1'b1;
        tick();
        xbase = xq_data.size(); sbase = start_n; tbase = txq.size();
        smp.delete();
        len = eff_len(0);
        for (int i = 0; i < len; i++) smp.push_back(16'($urandom));
        for (int i = 0; i < len; i++) begin
            if (i == 100) i_enable = 1'b0;
            send_sample(smp[i], 1);
        end
        repeat (2) tick();
        check_x("frameB", xbase, sbase, smp);
        chk("frameB_last_idx", 64'(xq_idx[xq_idx.size()-1]), 64'd511);
        send_sample(16'h5555, 0);
        tick();
        chk("frameB_overrun_set", 64'(o_overrun), 64'd1);
        chk("frameB_dropped_no_x_valid", 64'(xq_data.size() - xbase), 64'(len));
        i_tx_ready = 1'b0;
        y = {16'($urandom), 16'($urandom)};
        build_words(16'd1, y);
        i_bp_y = y; i_bp_done = 1'b1; tick(); i_bp_done = 1'b0;
        repeat (20) tick();
        chk("frameB_no_load_while_not_ready", 64'(txq.size() - tbase), 64'd0);
        raise_cyc  = cyc;
        i_tx_ready = 1'b1;
        wait_cnt("frameB_frame_cnt", 16'd2, 40);
        check_tx("frameB", tbase);
        if (txq.size() > tbase) chk("frameB_first_load_cycle", 64'(txq_cyc[tbase]), 64'(raise_cyc + 2));

        // Frame C: random length, stray bp_done in COLLECT, enable drop together with the last sample
        tick();
        len = $urandom_range(1, 16);
        i_frame_len = (LOG_N_MAX + 1)'(len);
        i_enable    = 1'b1;
        tick();
        xbase = xq_data.size(); sbase = start_n; tbase = txq.size();
        smp.delete();
        for (int i = 0; i < len; i++) smp.push_back(16'($urandom));
        i_bp_y = '1; i_bp_done = 1'b1; tick(); i_bp_done = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (i == len - 1) i_enable = 1'b0;
            send_sample(smp[i], 2);
        end
        repeat (2) tick();
        check_x("frameC", xbase, sbase, smp);
        chk("frameC_overrun_sticky", 64'(o_overrun), 64'd1);
        y = {16'($urandom), 16'($urandom)};
        build_words(16'd2, y);
        i_bp_y = y; i_bp_done = 1'b1; tick(); i_bp_done = 1'b0;
        wait_cnt("frameC_frame_cnt", 16'd3, 40);
        check_tx("frameC", tbase);
        tick();
        chk("frameC_idle_busy", 64'(o_busy), 64'd0);

        // Frame D: reset while waiting after the first TX word
        i_frame_len = 2;
        i_enable    = 1'b1;
        tick();
        tbase = txq.size();
        send_sample(16'h1111, 0);
        send_sample(16'h2222, 0);
        repeat (2) tick();
        i_bp_y = {16'hBEEF, 16'hCAFE}; i_bp_done = 1'b1; tick(); i_bp_done = 1'b0;
        for (int k = 0; k < 20 && o_tx_load !== 1'b1; k++) tick();
        chk("frameD_first_load_seen", 64'(o_tx_load), 64'd1);
        i_sys_rst = 1'b0;
        i_enable  = 1'b0;
        tick();
        check_zero("rstD");
        i_sys_rst = 1'b1;
        repeat (10) tick();
        chk("rstD_no_second_word", 64'(txq.size() - tbase), 64'd1);
        chk("rstD_still_idle", 64'(o_busy), 64'd0);

        chk("tx_load_never_with_ready_low", 64'(ready_viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
